// File: rtl/yuv2rgb_pipe_pkg.sv
// ============================================================================
// Module   : yuv2rgb_pipe_pkg
// Brief    : Shared constants and the saturation helper for the YUV->RGB path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package yuv2rgb_pipe_pkg;

    localparam int unsigned YUV2RGB_LATENCY = 5;

    // Q8 BT.601 full-range decode coefficients
    localparam logic signed [18:0] K_RV = 19'sd359;
    localparam logic signed [18:0] K_GU = 19'sd88;
    localparam logic signed [18:0] K_GV = 19'sd183;
    localparam logic signed [18:0] K_BU = 19'sd454;

    localparam logic signed [8:0]  CHROMA_OFS = 9'sd128;
    localparam logic signed [18:0] RND        = 19'sd128;
    localparam int unsigned        FRAC       = 8;

    function automatic logic [7:0] clamp_u8(input logic signed [10:0] a);
        logic [7:0] r;
        if (a < 11'sd0) begin
            r = 8'h00;
        end else if (a > 11'sd255) begin
            r = 8'hFF;
        end else begin
            r = a[7:0];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sideband_pipe.sv
// ============================================================================
// Module   : sideband_pipe
// Brief    : Synchronous-reset shift pipe keeping sideband aligned with data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sideband_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/yuv2rgb_pipe.sv
// ============================================================================
// Module   : yuv2rgb_pipe
// Brief    : Five-stage BT.601 YUV->RGB converter with aligned 3-bit sideband.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module yuv2rgb_pipe
    import yuv2rgb_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_y,
    input  logic [7:0] in_u,
    input  logic [7:0] in_v,
    input  logic [2:0] in_c,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic [2:0] out_c
);

    logic        [7:0]  r_y1;
    logic signed [8:0]  r_u1;
    logic signed [8:0]  r_v1;

    logic        [7:0]  r_y2;
    logic signed [18:0] r_p_rv;
    logic signed [18:0] r_p_gu;
    logic signed [18:0] r_p_gv;
    logic signed [18:0] r_p_bu;

    logic signed [18:0] r_sum_r;
    logic signed [18:0] r_sum_g;
    logic signed [18:0] r_sum_b;

    logic signed [10:0] r_sh_r;
    logic signed [10:0] r_sh_g;
    logic signed [10:0] r_sh_b;

    logic signed [8:0]  w_u_ofs;
    logic signed [8:0]  w_v_ofs;
    logic signed [18:0] w_y256;

    // Chroma range -128..127 fits a 9-bit signed value without wrap
    assign w_u_ofs = $signed({1'b0, in_u}) - CHROMA_OFS;
    assign w_v_ofs = $signed({1'b0, in_v}) - CHROMA_OFS;
    assign w_y256  = $signed({3'b000, r_y2, 8'h00});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y1    <= '0;
            r_u1    <= '0;
            r_v1    <= '0;
            r_y2    <= '0;
            r_p_rv  <= '0;
            r_p_gu  <= '0;
            r_p_gv  <= '0;
            r_p_bu  <= '0;
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
            r_sh_r  <= '0;
            r_sh_g  <= '0;
            r_sh_b  <= '0;
            out_r   <= '0;
            out_g   <= '0;
            out_b   <= '0;
        end else begin
            r_y1    <= in_y;
            r_u1    <= w_u_ofs;
            r_v1    <= w_v_ofs;

            r_y2    <= r_y1;
            r_p_rv  <= K_RV * 19'(r_v1);
            r_p_gu  <= K_GU * 19'(r_u1);
            r_p_gv  <= K_GV * 19'(r_v1);
            r_p_bu  <= K_BU * 19'(r_u1);

            r_sum_r <= w_y256 + r_p_rv + RND;
            r_sum_g <= w_y256 - r_p_gu - r_p_gv + RND;
            r_sum_b <= w_y256 + r_p_bu + RND;

            // Arithmetic shift floors toward -inf; |result| stays below 2^10
            r_sh_r  <= 11'(r_sum_r >>> FRAC);
            r_sh_g  <= 11'(r_sum_g >>> FRAC);
            r_sh_b  <= 11'(r_sum_b >>> FRAC);

            out_r   <= clamp_u8(r_sh_r);
            out_g   <= clamp_u8(r_sh_g);
            out_b   <= clamp_u8(r_sh_b);
        end
    end

    sideband_pipe #(
        .WIDTH (3),
        .DEPTH (YUV2RGB_LATENCY)
    ) u_sideband (
        .clk (clk),
        .rst (rst),
        .i_d (in_c),
        .o_q (out_c)
    );

endmodule

`default_nettype wire

// File: tb/tb_yuv2rgb_pipe.sv
// ============================================================================
// Module   : tb_yuv2rgb_pipe
// Brief    : Self-checking bench for yuv2rgb_pipe against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_yuv2rgb_pipe;

    logic       clk;
    logic       rst;
    logic [7:0] in_y;
    logic [7:0] in_u;
    logic [7:0] in_v;
    logic [2:0] in_c;
    logic [7:0] out_r;
    logic [7:0] out_g;
    logic [7:0] out_b;
    logic [2:0] out_c;

    int checks   = 0;
    int failures = 0;

    // Expected {R,G,B,C} per edge; the output after an edge is the entry
    // pushed four edges earlier (the capture edge counts as the first of five).
    logic [26:0] hist[$];

    yuv2rgb_pipe dut (
        .clk   (clk),
        .rst   (rst),
        .in_y  (in_y),
        .in_u  (in_u),
        .in_v  (in_v),
        .in_c  (in_c),
        .out_r (out_r),
        .out_g (out_g),
        .out_b (out_b),
        .out_c (out_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] sat(input int x);
        if (x < 0)   return 8'd0;
        if (x > 255) return 8'd255;
        return 8'(x);
    endfunction

    function automatic logic [26:0] model(input int y, input int u, input int v,
                                          input logic [2:0] c);
        int up, vp, r, g, b;
        up = u - 128;
        vp = v - 128;
        r  = (256*y + 359*vp + 128) >>> 8;
        g  = (256*y - 88*up - 183*vp + 128) >>> 8;
        b  = (256*y + 454*up + 128) >>> 8;
        return {sat(r), sat(g), sat(b), c};
    endfunction

    function automatic logic [26:0] observed();
        return {out_r, out_g, out_b, out_c};
    endfunction

    function automatic logic [26:0] expected();
        return hist[hist.size()-5];
    endfunction

    task automatic step(input logic r, input logic [7:0] y, input logic [7:0] u,
                        input logic [7:0] v, input logic [2:0] c);
        rst  = r;
        in_y = y;
        in_u = u;
        in_v = v;
        in_c = c;
        @(posedge clk);
        #1;
        if (r) begin
            hist.delete();
            repeat (5) hist.push_back('0);
        end else begin
            hist.push_back(model(int'(y), int'(u), int'(v), c));
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    task automatic step_rand(input logic r);
        step(r, 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
    endtask

    task automatic test_reset();
        step_rand(1'b1);
        checks++;
        if (observed() !== 27'd0) begin
            failures++;
            $display("FAIL reset_first_edge: got %h want %h", observed(), 27'd0);
        end
        step_rand(1'b1);
        checks++;
        if (observed() !== 27'd0) begin
            failures++;
            $display("FAIL reset_hold: got %h want %h", observed(), 27'd0);
        end
    endtask

    task automatic test_midgrey();
        logic [26:0] want;
        step(1'b0, 8'd128, 8'd128, 8'd128, 3'b101);
        for (int e = 1; e <= 6; e++) begin
            if (e > 1) step(1'b0, 8'd0, 8'd128, 8'd128, 3'b000);
            want = (e == 5) ? {8'd128, 8'd128, 8'd128, 3'b101} : 27'd0;
            checks++;
            if (observed() !== want) begin
                failures++;
                $display("FAIL midgrey_edge%0d: got %h want %h", e, observed(), want);
            end
        end
    endtask

    task automatic test_corners();
        logic [7:0]  ty [6] = '{8'd0,   8'd255, 8'd255, 8'd1,   8'd255, 8'd77};
        logic [7:0]  tu [6] = '{8'd128, 8'd0,   8'd255, 8'd127, 8'd128, 8'd128};
        logic [7:0]  tv [6] = '{8'd255, 8'd128, 8'd255, 8'd128, 8'd129, 8'd128};
        logic [2:0]  tc [6] = '{3'd1,   3'd2,   3'd3,   3'd4,   3'd6,   3'd7};
        logic [23:0] trgb [6] = '{{8'd178, 8'd0,   8'd0},
                                  {8'd255, 8'd255, 8'd28},
                                  {8'd255, 8'd121, 8'd255},
                                  {8'd1,   8'd1,   8'd0},
                                  {8'd255, 8'd254, 8'd255},
                                  {8'd77,  8'd77,  8'd77}};
        logic [26:0] want;
        for (int e = 0; e < 10; e++) begin
            if (e < 6) step(1'b0, ty[e], tu[e], tv[e], tc[e]);
            else       step(1'b0, 8'd0, 8'd128, 8'd128, 3'd0);
            if (e >= 4) begin
                want = {trgb[e-4], tc[e-4]};
                checks++;
                if (observed() !== want) begin
                    failures++;
                    $display("FAIL corner%0d: got %h want %h", e-4, observed(), want);
                end
            end
        end
    endtask

    task automatic test_grey_sweep();
        logic [7:0] y;
        for (int e = 0; e < 40; e++) begin
            y = 8'($urandom);
            if (e == 0) y = 8'd0;
            if (e == 1) y = 8'd255;
            step(1'b0, y, 8'd128, 8'd128, 3'($urandom));
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL grey_sweep%0d: got %h want %h", e, observed(), expected());
            end
        end
    endtask

    task automatic test_stream();
        for (int e = 0; e < 1000; e++) begin
            step_rand(1'b0);
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL stream%0d: got %h want %h", e, observed(), expected());
            end
        end
    endtask

    task automatic test_reset_midstream();
        repeat (8) step_rand(1'b0);
        step_rand(1'b1);
        checks++;
        if (observed() !== 27'd0) begin
            failures++;
            $display("FAIL midrst_assert: got %h want %h", observed(), 27'd0);
        end
        for (int e = 1; e <= 4; e++) begin
            step_rand(1'b0);
            checks++;
            if (observed() !== 27'd0) begin
                failures++;
                $display("FAIL midrst_zero%0d: got %h want %h", e, observed(), 27'd0);
            end
        end
        for (int e = 5; e <= 14; e++) begin
            step_rand(1'b0);
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL midrst_refill%0d: got %h want %h", e, observed(), expected());
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        in_y = '0;
        in_u = '0;
        in_v = '0;
        in_c = '0;
        test_reset();
        test_midgrey();
        test_corners();
        test_grey_sweep();
        test_stream();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
